// File: rtl/uart9_rx.sv
// uart9_rx: 8N1 receiver that reassembles 9-bit words from little-endian byte pairs
// Ports: clk, reset (sync, active-high), rx (async serial line, idle high),
//        data9 (last good word), valid (1-cycle strobe on update),
//        frame_err (1-cycle strobe on a discarded pair), busy (byte or pair in flight).
// Build option: UART9_RX_MAJORITY_EN selects 2-of-3 majority sampling around each sample instant.
module uart9_rx #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int GAP_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [8:0] data9,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int GAP  = GAP_BITS * DIV;
  localparam int CW   = $clog2(DIV);
  localparam int GW   = $clog2(GAP + 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, WAIT_IDLE = 3'd4;
  logic          rs_meta, rs, smp, slot;
  logic [2:0]    state, nbit;
  logic [CW-1:0] cnt;
  logic [7:0]    sh, lo;
  logic [GW-1:0] gap;
  logic          tick, tick_start, done, tmo;
`ifdef UART9_RX_MAJORITY_EN
  // Decision is taken one cycle after the nominal instant so the sample after it is available;
  // moving the start decision by one cycle shifts every later sample point by the same amount.
  localparam int FIRST = HALF;
  logic rs_d1, rs_d2;
  always_ff @(posedge clk)
    if (reset) {rs_d2, rs_d1} <= 2'b11;
    else {rs_d2, rs_d1} <= {rs_d1, rs};
  assign smp = (rs_d2 & rs_d1) | (rs_d2 & rs) | (rs_d1 & rs);
`else
  localparam int FIRST = HALF - 1;
  assign smp = rs;
`endif
  assign tick       = cnt == CW'(DIV - 1);
  assign tick_start = cnt == CW'(FIRST);
  assign done       = state == STOP && tick && smp;
  assign tmo        = slot && state == IDLE && gap == GW'(GAP - 1);
  assign busy       = state != IDLE || slot;
  always_ff @(posedge clk) begin
    if (reset) begin
      {rs_meta, rs} <= 2'b11;
      state         <= IDLE;
      cnt           <= '0;
      nbit          <= '0;
      sh            <= '0;
      lo            <= '0;
      slot          <= 1'b0;
      gap           <= '0;
      data9         <= '0;
      valid         <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rs_meta   <= rx;
      rs        <= rs_meta;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (!rs) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (tick_start) begin
          cnt   <= '0;
          nbit  <= '0;
          state <= smp ? IDLE : DATA;
        end else cnt <= cnt + CW'(1);
        DATA: if (tick) begin
          cnt   <= '0;
          sh    <= {smp, sh[7:1]};
          nbit  <= nbit + 3'd1;
          state <= nbit == 3'd7 ? STOP : DATA;
        end else cnt <= cnt + CW'(1);
        STOP: if (tick) begin
          cnt   <= '0;
          state <= smp ? IDLE : WAIT_IDLE;
          if (!smp) begin
            frame_err <= 1'b1;
            slot      <= 1'b0;
          end
        end else cnt <= cnt + CW'(1);
        WAIT_IDLE: if (rs) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (done) begin
        if (!slot) begin
          lo   <= sh;
          slot <= 1'b1;
          gap  <= '0;
        end else begin
          slot <= 1'b0;
          if (sh[7:1] == 7'd0) begin
            data9 <= {sh[0], lo};
            valid <= 1'b1;
          end else frame_err <= 1'b1;
        end
      end
      // A start edge seen on the terminal cycle still launches START, but with slot cleared
      // that byte becomes a fresh low byte.
      if (tmo) begin
        frame_err <= 1'b1;
        slot      <= 1'b0;
        gap       <= '0;
      end else if (slot && state == IDLE) gap <= gap + GW'(1);
    end
  end
endmodule

// File: tb/tb_uart9_rx.sv
// tb_uart9_rx: randomized byte-pair stimulus checked against a pair-level reference model
module tb_uart9_rx;
  localparam int CLK_HZ = 160, BAUD = 10, GAP_BITS = 20;
  localparam int DIV = CLK_HZ / BAUD, HALF = DIV / 2, GAP = GAP_BITS * DIV;
`ifdef UART9_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // start-bit drive to the edge that registers the stop-bit decision: 2 sync stages, IDLE->START edge,
  // half a bit to the start sample, then nine full bits
  localparam int LAT = 3 + HALF + 9 * DIV + MAJ;
  localparam int FERR_EV = 'h1000;
  logic clk = 0, reset = 1, rx = 1;
  logic [8:0] data9;
  logic valid, frame_err, busy;
  int cyc = 0, n_tests = 0, n_fail = 0, both = 0;
  int last_valid_cyc = -1, last_ferr_cyc = -1;
  int obs[$], exp_q[$];
  bit m_slot = 0;
  logic [7:0] m_lo = 0;
  int m_data = 0;

  uart9_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .GAP_BITS(GAP_BITS)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data9(data9), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid) begin
      obs.push_back(int'(data9));
      last_valid_cyc = cyc;
    end
    if (frame_err) begin
      obs.push_back(FERR_EV);
      last_ferr_cyc = cyc;
    end
    if (valid && frame_err) both++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, int got, int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(logic [7:0] b, bit stop_ok, output int t0);
    t0 = cyc;
    rx = 0;
    wait_cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(DIV);
    end
    rx = stop_ok;
    wait_cycles(DIV);
    rx = 1;
    if (!stop_ok) begin
      exp_q.push_back(FERR_EV);
      m_slot = 0;
    end else if (!m_slot) begin
      m_lo = b;
      m_slot = 1;
    end else begin
      m_slot = 0;
      if (b[7:1] == 7'd0) begin
        m_data = {b[0], m_lo};
        exp_q.push_back(m_data);
      end else exp_q.push_back(FERR_EV);
    end
  endtask

  task automatic idle_bits(int n);
    rx = 1;
    wait_cycles(n * DIV);
    if (m_slot && n * DIV >= GAP) begin
      exp_q.push_back(FERR_EV);
      m_slot = 0;
    end
  endtask

  task automatic send_pair(logic [7:0] lo_b, logic [7:0] hi_b, int gap_bits);
    int t;
    send_byte(lo_b, 1, t);
    if (gap_bits > 0) idle_bits(gap_bits);
    send_byte(hi_b, 1, t);
  endtask

  task automatic checkpoint(string tag);
    wait_cycles(2 * DIV);
    check({tag, ".events"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) check({tag, ".ev"}, obs[i], exp_q[i]);
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    int t;
    wait_cycles(3);
    check("rst.data9", data9, 0);
    check("rst.valid", valid, 0);
    check("rst.ferr", frame_err, 0);
    check("rst.busy", busy, 0);
    reset = 0;
    idle_bits(2);
    send_byte(8'hA5, 1, t);
    send_byte(8'h01, 1, t);
    check("t1.lat", last_valid_cyc, t + LAT);
    check("t1.data9", data9, 'h1A5);
    check("t1.busy", busy, 0);
    checkpoint("t1");
    send_pair(8'hFF, 8'h00, 0);
    idle_bits(1);
    send_pair(8'h00, 8'h01, 1);
    checkpoint("t2");
    check("t2.data9", data9, 'h100);
    send_pair(8'h3C, 8'h03, 0);
    check("t3.hold", data9, m_data);
    idle_bits(1);
    send_pair(8'h10, 8'h01, 0);
    checkpoint("t3");
    check("t3.data9", data9, 'h110);
    send_byte(8'h55, 0, t);
    idle_bits(2);
    send_pair(8'h55, 8'h00, 0);
    checkpoint("t4");
    check("t4.data9", data9, 'h055);
    send_byte(8'h7E, 1, t);
    idle_bits(GAP_BITS + 1);
    check("t5.tmo", last_ferr_cyc, t + LAT + GAP);
    check("t5.busy", busy, 0);
    send_pair(8'h01, 8'h01, 0);
    checkpoint("t5");
    check("t5.data9", data9, 'h101);
    rx = 0;
    wait_cycles(DIV * 2 / 5);
    idle_bits(2);
    checkpoint("t6.glitch");
    rx = 0;
    wait_cycles(4 * DIV);
    reset = 1;
    rx = 1;
    wait_cycles(2);
    check("t6.rst.data9", data9, 0);
    check("t6.rst.valid", valid, 0);
    check("t6.rst.ferr", frame_err, 0);
    check("t6.rst.busy", busy, 0);
    reset = 0;
    m_slot = 0;
    m_data = 0;
    obs.delete();
    exp_q.delete();
    idle_bits(2);
    send_pair(8'h02, 8'h00, 0);
    checkpoint("t6");
    check("t6.data9", data9, 'h002);
    for (int k = 0; k < 12; k++) begin
      logic [7:0] lo_b, hi_b;
      lo_b = 8'($urandom);
      hi_b = $urandom_range(0, 3) == 0 ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
      send_pair(lo_b, hi_b, int'($urandom_range(0, 2)));
      idle_bits(int'($urandom_range(0, 2)));
    end
    checkpoint("rnd");
    check("rnd.data9", data9, m_data);
    check("excl", both, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
